game_round_controller: RTL and testbench
========================================

GAME_ROUND_CONTROLLER -- requirements
Module: game_round_controller

Interface
REQ-001 Parameter FRAMES_PER_SEC, default 60, number of nf_in pulses per countdown step.
REQ-002 Parameter HIT_PAUSE_FRAMES, default 30, number of frames the display is frozen after a hit.
REQ-003 Parameter GAMEOVER_FRAMES, default 300, number of frames the result is held before returning to idle.
REQ-004 Parameter START_HEALTH, default 5, initial health per fighter (3 bits, 1..7).
REQ-005 clk_in  input  1  system/pixel clock; the only clock.
REQ-006 rst_in  input  1  synchronous, active-high reset.
REQ-007 ir_in  input  32  decoded IR remote code.
REQ-008 ir_valid_in  input  1  one-cycle strobe; ir_in is valid only in this cycle.
REQ-009 nf_in  input  1  one-cycle new-frame strobe.
REQ-010 player_hit_in  input  1  one-cycle strobe: the player was struck.
REQ-011 opponent_hit_in  input  1  one-cycle strobe: the opponent was struck.
REQ-012 display_start_out  output  1  high selects the start-screen image.
REQ-013 game_state_out  output  3  current state encoding.
REQ-014 countdown_out  output  2  seconds remaining in COUNTDOWN (3..1); 0 otherwise.
REQ-015 player_health_out, opponent_health_out  output  3 each  current health values.
REQ-016 freeze_out  output  1  high tells the saber and trace datapath to hold its positions.
REQ-017 winner_out  output  2  0 none, 1 player, 2 opponent, 3 draw.

Function
REQ-018 The state machine SHALL have states IDLE=0, COUNTDOWN=1, FIGHT=2, HIT_PAUSE=3, GAME_OVER=4; all outputs are registered and change one cycle after the triggering input.
REQ-019 IDLE: display_start_out=1; a start code (32'h20DF_5BA4 or 32'h20DF_5AA5) with ir_valid_in high SHALL move to COUNTDOWN, load both health values to START_HEALTH, set countdown_out=3 and winner_out=0, and clear the frame counter.
REQ-020 COUNTDOWN: the frame counter SHALL increment on each nf_in pulse. When it reaches FRAMES_PER_SEC-1 and nf_in is high, the counter clears and countdown_out decrements. A decrement from 1 SHALL instead enter FIGHT with countdown_out=0, so COUNTDOWN lasts exactly 3*FRAMES_PER_SEC frames.
REQ-021 FIGHT: on any hit strobe, each struck fighter's health SHALL decrement by 1, saturating at 0. If any health becomes 0, enter GAME_OVER; otherwise enter HIT_PAUSE with the frame counter cleared.
REQ-022 If both hit strobes occur in the same cycle, both health values SHALL decrement. If both reach 0, winner_out=3 (draw); if only one reaches 0, the other fighter wins.
REQ-023 Hit strobes outside FIGHT SHALL be ignored.
REQ-024 HIT_PAUSE: freeze_out=1; after HIT_PAUSE_FRAMES nf_in pulses, return to FIGHT.
REQ-025 GAME_OVER: freeze_out=1 and winner_out is held; after GAMEOVER_FRAMES nf_in pulses, or on a valid start code, go to IDLE. The start code takes priority if both occur in the same cycle.
REQ-026 In any state other than IDLE, the abort code 32'h20DF_10EF with ir_valid_in high SHALL go to IDLE. Abort has priority over hit strobes and frame-count transitions in the same cycle.
REQ-027 display_start_out SHALL be 1 only in IDLE; freeze_out SHALL be 1 only in HIT_PAUSE and GAME_OVER.
REQ-028 The frame counter SHALL be wide enough for the largest of the three frame parameters. It SHALL never wrap within a state: it clears on every state entry.
REQ-029 ir_in SHALL be ignored when ir_valid_in is low. Unrecognised codes SHALL have no effect.

Reset
REQ-030 While rst_in is high, on each clock edge: state=IDLE, display_start_out=1, countdown_out=0, freeze_out=0, winner_out=0, health outputs=START_HEALTH, frame counter=0.
REQ-031 Reset asserted mid-operation SHALL override all other inputs in that cycle.

Structure
REQ-032 The state enum, IR code constants and winner encodings SHALL live in a shared package, game_pkg, for use by the display and game-logic modules.
REQ-033 One sub-module, frame_timer, SHALL implement the nf_in-driven counter with clear and terminal-count outputs; the FSM instantiates it once.

Verification
REQ-034 Reset, then IR 32'h20DF_5BA4 with strobe -> next cycle state=1, countdown_out=3, health=5/5, display_start_out=0.
REQ-035 From COUNTDOWN, 180 nf_in pulses (FRAMES_PER_SEC=60) -> countdown_out goes 3, 2, 1; state=2 the cycle after the 180th pulse, never earlier.
REQ-036 In FIGHT, player_hit_in once -> player_health_out=4, state=3, freeze_out=1; after 30 nf_in pulses -> state=2, freeze_out=0.
REQ-037 Both fighters at health 1, simultaneous hit strobes -> state=4, both health 0, winner_out=3. A hit strobe issued in GAME_OVER leaves both health values at 0.
REQ-038 Abort code in HIT_PAUSE in the same cycle as the terminal frame pulse -> state=0, display_start_out=1.
REQ-039 rst_in asserted during COUNTDOWN with nf_in high -> state=0, countdown_out=0, health=5/5 next cycle.

Source files
------------

// File: rtl/game_round_controller_pkg.sv
// Shared game definitions: FSM states, IR remote codes, winner encodings.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_FIGHT     = 3'd2,
    ST_HIT_PAUSE = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_e;

  typedef enum logic [1:0] {
    WIN_NONE     = 2'd0,
    WIN_PLAYER   = 2'd1,
    WIN_OPPONENT = 2'd2,
    WIN_DRAW     = 2'd3
  } winner_e;

  localparam logic [31:0] IR_START_A = 32'h20DF_5BA4;
  localparam logic [31:0] IR_START_B = 32'h20DF_5AA5;
  localparam logic [31:0] IR_ABORT   = 32'h20DF_10EF;

  function automatic logic is_start_code(input logic valid, input logic [31:0] code);
    return valid && ((code == IR_START_A) || (code == IR_START_B));
  endfunction

  function automatic logic is_abort_code(input logic valid, input logic [31:0] code);
    return valid && (code == IR_ABORT);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/game_round_controller_frame_timer.sv
// Frame counter advanced by new-frame strobes, with synchronous clear and a
// terminal-count flag that fires on the strobe that lands on term_in.
module frame_timer #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_in,
  input  logic             tick_in,
  input  logic [CNT_W-1:0] term_in,
  output logic             tc_out
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear wins over advance.
  always_comb begin
    count_d = count_q;
    if (clear_in) begin
      count_d = '0;
    end else if (tick_in) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_out = tick_in && (count_q == term_in);

endmodule

// File: rtl/game_round_controller.sv
// Round controller for the saber game: start screen, 3-2-1 countdown, fight
// with health tracking, hit freeze, and a timed result screen.
module game_round_controller
  import game_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC   = 60,
  parameter int unsigned HIT_PAUSE_FRAMES = 30,
  parameter int unsigned GAMEOVER_FRAMES  = 300,
  parameter int unsigned START_HEALTH     = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] ir_in,
  input  logic        ir_valid_in,
  input  logic        nf_in,
  input  logic        player_hit_in,
  input  logic        opponent_hit_in,
  output logic        display_start_out,
  output logic [2:0]  game_state_out,
  output logic [1:0]  countdown_out,
  output logic [2:0]  player_health_out,
  output logic [2:0]  opponent_health_out,
  output logic        freeze_out,
  output logic [1:0]  winner_out
);

  localparam int unsigned FRAME_MAX = max3(FRAMES_PER_SEC, HIT_PAUSE_FRAMES, GAMEOVER_FRAMES);
  localparam int unsigned CNT_W     = $clog2(FRAME_MAX + 1);

  localparam logic [CNT_W-1:0] CD_TERM = CNT_W'(FRAMES_PER_SEC - 1);
  localparam logic [CNT_W-1:0] HP_TERM = CNT_W'(HIT_PAUSE_FRAMES - 1);
  localparam logic [CNT_W-1:0] GO_TERM = CNT_W'(GAMEOVER_FRAMES - 1);
  localparam logic [2:0]       START_H = 3'(START_HEALTH);

  game_state_e state_q, state_d;
  winner_e     winner_q, winner_d;
  logic [1:0]  countdown_q, countdown_d;
  logic [2:0]  p_health_q, p_health_d;
  logic [2:0]  o_health_q, o_health_d;
  logic        display_q, display_d;
  logic        freeze_q, freeze_d;

  logic             timer_clear;
  logic             timer_tick;
  logic [CNT_W-1:0] timer_term;
  logic             timer_tc;

  logic       start_cmd;
  logic       abort_cmd;
  logic       any_hit;
  logic [2:0] p_dec;
  logic [2:0] o_dec;

  assign start_cmd = is_start_code(ir_valid_in, ir_in);
  assign abort_cmd = is_abort_code(ir_valid_in, ir_in);
  assign any_hit   = player_hit_in || opponent_hit_in;
  assign p_dec     = p_health_q - {2'b00, (player_hit_in && (p_health_q != 3'd0))};
  assign o_dec     = o_health_q - {2'b00, (opponent_hit_in && (o_health_q != 3'd0))};

  frame_timer #(
    .CNT_W (CNT_W)
  ) u_frame_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (timer_clear),
    .tick_in  (timer_tick),
    .term_in  (timer_term),
    .tc_out   (timer_tc)
  );

  // Next-state, game data and registered-output decode.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    countdown_d = countdown_q;
    p_health_d  = p_health_q;
    o_health_d  = o_health_q;
    timer_clear = 1'b0;
    timer_tick  = 1'b0;
    timer_term  = CD_TERM;

    case (state_q)
      ST_IDLE: begin
        if (start_cmd) begin
          state_d     = ST_COUNTDOWN;
          p_health_d  = START_H;
          o_health_d  = START_H;
          countdown_d = 2'd3;
          winner_d    = WIN_NONE;
        end
      end
      ST_COUNTDOWN: begin
        timer_term = CD_TERM;
        timer_tick = nf_in;
        if (abort_cmd) begin
          state_d = ST_IDLE;
        end else if (timer_tc) begin
          timer_clear = 1'b1;
          if (countdown_q == 2'd1) begin
            state_d = ST_FIGHT;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end
      end
      ST_FIGHT: begin
        if (abort_cmd) begin
          state_d = ST_IDLE;
        end else if (any_hit) begin
          p_health_d = p_dec;
          o_health_d = o_dec;
          if ((p_dec == 3'd0) || (o_dec == 3'd0)) begin
            state_d = ST_GAME_OVER;
            if ((p_dec == 3'd0) && (o_dec == 3'd0)) begin
              winner_d = WIN_DRAW;
            end else if (p_dec == 3'd0) begin
              winner_d = WIN_OPPONENT;
            end else begin
              winner_d = WIN_PLAYER;
            end
          end else begin
            state_d = ST_HIT_PAUSE;
          end
        end
      end
      ST_HIT_PAUSE: begin
        timer_term = HP_TERM;
        timer_tick = nf_in;
        if (abort_cmd) begin
          state_d = ST_IDLE;
        end else if (timer_tc) begin
          state_d = ST_FIGHT;
        end
      end
      ST_GAME_OVER: begin
        timer_term = GO_TERM;
        timer_tick = nf_in;
        if (abort_cmd || start_cmd || timer_tc) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every state entry restarts the frame count so it never wraps in-state.
    if (state_d != state_q) begin
      timer_clear = 1'b1;
    end
    if (state_d != ST_COUNTDOWN) begin
      countdown_d = '0;
    end

    display_d = (state_d == ST_IDLE);
    freeze_d  = (state_d == ST_HIT_PAUSE) || (state_d == ST_GAME_OVER);
  end

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      winner_q    <= WIN_NONE;
      countdown_q <= '0;
      p_health_q  <= START_H;
      o_health_q  <= START_H;
      display_q   <= 1'b1;
      freeze_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      countdown_q <= countdown_d;
      p_health_q  <= p_health_d;
      o_health_q  <= o_health_d;
      display_q   <= display_d;
      freeze_q    <= freeze_d;
    end
  end

  assign display_start_out   = display_q;
  assign game_state_out      = state_q;
  assign countdown_out       = countdown_q;
  assign player_health_out   = p_health_q;
  assign opponent_health_out = o_health_q;
  assign freeze_out          = freeze_q;
  assign winner_out          = winner_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller with default parameters.
module tb_game_round_controller;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] ir_in = '0;
  logic        ir_valid_in = 1'b0;
  logic        nf_in = 1'b0;
  logic        player_hit_in = 1'b0;
  logic        opponent_hit_in = 1'b0;
  logic        display_start_out;
  logic [2:0]  game_state_out;
  logic [1:0]  countdown_out;
  logic [2:0]  player_health_out;
  logic [2:0]  opponent_health_out;
  logic        freeze_out;
  logic [1:0]  winner_out;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  localparam logic [31:0] START_A = 32'h20DF_5BA4;
  localparam logic [31:0] START_B = 32'h20DF_5AA5;
  localparam logic [31:0] ABORT   = 32'h20DF_10EF;

  game_round_controller #(
    .FRAMES_PER_SEC   (60),
    .HIT_PAUSE_FRAMES (30),
    .GAMEOVER_FRAMES  (300),
    .START_HEALTH     (5)
  ) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .ir_in               (ir_in),
    .ir_valid_in         (ir_valid_in),
    .nf_in               (nf_in),
    .player_hit_in       (player_hit_in),
    .opponent_hit_in     (opponent_hit_in),
    .display_start_out   (display_start_out),
    .game_state_out      (game_state_out),
    .countdown_out       (countdown_out),
    .player_health_out   (player_health_out),
    .opponent_health_out (opponent_health_out),
    .freeze_out          (freeze_out),
    .winner_out          (winner_out)
  );

  always #5 clk_in = ~clk_in;

  // Packed view of all outputs: state, countdown, p_hp, o_hp, display, freeze, winner.
  function automatic logic [14:0] snap();
    return {game_state_out, countdown_out, player_health_out, opponent_health_out,
            display_start_out, freeze_out, winner_out};
  endfunction

  function automatic logic [14:0] exp_v(input logic [2:0] st, input logic [1:0] cd,
                                        input logic [2:0] ph, input logic [2:0] oh,
                                        input logic ds, input logic fz, input logic [1:0] w);
    return {st, cd, ph, oh, ds, fz, w};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic nf_pulses(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      nf_in = 1'b1;
      step();
      nf_in = 1'b0;
      step();
    end
  endtask

  task automatic send_ir(input logic [31:0] code);
    ir_in = code;
    ir_valid_in = 1'b1;
    step();
    ir_valid_in = 1'b0;
    ir_in = '0;
  endtask

  task automatic hit(input logic p, input logic o);
    player_hit_in = p;
    opponent_hit_in = o;
    step();
    player_hit_in = 1'b0;
    opponent_hit_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    n_cmp++;
    if (snap() !== exp_v(3'd0, 2'd0, 3'd5, 3'd5, 1'b1, 1'b0, 2'd0)) begin
      $display("FAIL reset_state got %h want %h", snap(), exp_v(3'd0, 2'd0, 3'd5, 3'd5, 1'b1, 1'b0, 2'd0));
      n_err++;
    end
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_start();
    send_ir(32'h20DF_1234);
    n_cmp++;
    if (game_state_out !== 3'd0) begin
      $display("FAIL unknown_code got %0d want 0", game_state_out);
      n_err++;
    end
    ir_in = START_A;
    step();
    ir_in = '0;
    n_cmp++;
    if (game_state_out !== 3'd0) begin
      $display("FAIL start_no_valid got %0d want 0", game_state_out);
      n_err++;
    end
    send_ir(ABORT);
    n_cmp++;
    if (snap() !== exp_v(3'd0, 2'd0, 3'd5, 3'd5, 1'b1, 1'b0, 2'd0)) begin
      $display("FAIL abort_in_idle got %h want %h", snap(), exp_v(3'd0, 2'd0, 3'd5, 3'd5, 1'b1, 1'b0, 2'd0));
      n_err++;
    end
    send_ir(START_A);
    n_cmp++;
    if (snap() !== exp_v(3'd1, 2'd3, 3'd5, 3'd5, 1'b0, 1'b0, 2'd0)) begin
      $display("FAIL start_entry got %h want %h", snap(), exp_v(3'd1, 2'd3, 3'd5, 3'd5, 1'b0, 1'b0, 2'd0));
      n_err++;
    end
  endtask

  task automatic test_countdown();
    logic [1:0] want_cd [6];
    int unsigned burst [6];
    want_cd = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    burst   = '{59, 1, 59, 1, 59, 1};
    for (int unsigned k = 0; k < 6; k++) begin
      nf_pulses(burst[k]);
      n_cmp++;
      if (k == 5) begin
        if (snap() !== exp_v(3'd2, 2'd0, 3'd5, 3'd5, 1'b0, 1'b0, 2'd0)) begin
          $display("FAIL countdown_to_fight got %h want %h", snap(), exp_v(3'd2, 2'd0, 3'd5, 3'd5, 1'b0, 1'b0, 2'd0));
          n_err++;
        end
      end else if (snap() !== exp_v(3'd1, want_cd[k], 3'd5, 3'd5, 1'b0, 1'b0, 2'd0)) begin
        $display("FAIL countdown_step%0d got %h want %h", k, snap(), exp_v(3'd1, want_cd[k], 3'd5, 3'd5, 1'b0, 1'b0, 2'd0));
        n_err++;
      end
    end
  endtask

  task automatic test_hit_pause();
    hit(1'b1, 1'b0);
    n_cmp++;
    if (snap() !== exp_v(3'd3, 2'd0, 3'd4, 3'd5, 1'b0, 1'b1, 2'd0)) begin
      $display("FAIL hit_entry got %h want %h", snap(), exp_v(3'd3, 2'd0, 3'd4, 3'd5, 1'b0, 1'b1, 2'd0));
      n_err++;
    end
    hit(1'b1, 1'b1);
    n_cmp++;
    if (snap() !== exp_v(3'd3, 2'd0, 3'd4, 3'd5, 1'b0, 1'b1, 2'd0)) begin
      $display("FAIL hit_in_pause got %h want %h", snap(), exp_v(3'd3, 2'd0, 3'd4, 3'd5, 1'b0, 1'b1, 2'd0));
      n_err++;
    end
    nf_pulses(29);
    n_cmp++;
    if (game_state_out !== 3'd3) begin
      $display("FAIL pause_early got %0d want 3", game_state_out);
      n_err++;
    end
    nf_pulses(1);
    n_cmp++;
    if (snap() !== exp_v(3'd2, 2'd0, 3'd4, 3'd5, 1'b0, 1'b0, 2'd0)) begin
      $display("FAIL pause_exit got %h want %h", snap(), exp_v(3'd2, 2'd0, 3'd4, 3'd5, 1'b0, 1'b0, 2'd0));
      n_err++;
    end
  endtask

  task automatic test_draw();
    hit(1'b1, 1'b1); nf_pulses(30);
    hit(1'b1, 1'b1); nf_pulses(30);
    hit(1'b1, 1'b1); nf_pulses(30);
    hit(1'b0, 1'b1); nf_pulses(30);
    n_cmp++;
    if (snap() !== exp_v(3'd2, 2'd0, 3'd1, 3'd1, 1'b0, 1'b0, 2'd0)) begin
      $display("FAIL draw_setup got %h want %h", snap(), exp_v(3'd2, 2'd0, 3'd1, 3'd1, 1'b0, 1'b0, 2'd0));
      n_err++;
    end
    hit(1'b1, 1'b1);
    n_cmp++;
    if (snap() !== exp_v(3'd4, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1, 2'd3)) begin
      $display("FAIL draw_result got %h want %h", snap(), exp_v(3'd4, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1, 2'd3));
      n_err++;
    end
    hit(1'b1, 1'b1);
    n_cmp++;
    if (snap() !== exp_v(3'd4, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1, 2'd3)) begin
      $display("FAIL hit_in_gameover got %h want %h", snap(), exp_v(3'd4, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1, 2'd3));
      n_err++;
    end
    send_ir(START_B);
    n_cmp++;
    if ({game_state_out, display_start_out, freeze_out, countdown_out} !== {3'd0, 1'b1, 1'b0, 2'd0}) begin
      $display("FAIL gameover_start got %h want %h", {game_state_out, display_start_out, freeze_out, countdown_out}, {3'd0, 1'b1, 1'b0, 2'd0});
      n_err++;
    end
  endtask

  task automatic test_gameover_timeout();
    send_ir(START_B);
    n_cmp++;
    if (snap() !== exp_v(3'd1, 2'd3, 3'd5, 3'd5, 1'b0, 1'b0, 2'd0)) begin
      $display("FAIL restart got %h want %h", snap(), exp_v(3'd1, 2'd3, 3'd5, 3'd5, 1'b0, 1'b0, 2'd0));
      n_err++;
    end
    nf_pulses(180);
    for (int unsigned i = 0; i < 4; i++) begin
      hit(1'b1, 1'b0);
      nf_pulses(30);
    end
    hit(1'b1, 1'b0);
    n_cmp++;
    if (snap() !== exp_v(3'd4, 2'd0, 3'd0, 3'd5, 1'b0, 1'b1, 2'd2)) begin
      $display("FAIL opponent_wins got %h want %h", snap(), exp_v(3'd4, 2'd0, 3'd0, 3'd5, 1'b0, 1'b1, 2'd2));
      n_err++;
    end
    nf_pulses(299);
    n_cmp++;
    if (snap() !== exp_v(3'd4, 2'd0, 3'd0, 3'd5, 1'b0, 1'b1, 2'd2)) begin
      $display("FAIL gameover_hold got %h want %h", snap(), exp_v(3'd4, 2'd0, 3'd0, 3'd5, 1'b0, 1'b1, 2'd2));
      n_err++;
    end
    nf_pulses(1);
    n_cmp++;
    if ({game_state_out, display_start_out, freeze_out} !== {3'd0, 1'b1, 1'b0}) begin
      $display("FAIL gameover_timeout got %h want %h", {game_state_out, display_start_out, freeze_out}, {3'd0, 1'b1, 1'b0});
      n_err++;
    end
  endtask

  task automatic test_abort_pause();
    send_ir(START_A);
    hit(1'b1, 1'b1);
    n_cmp++;
    if (snap() !== exp_v(3'd1, 2'd3, 3'd5, 3'd5, 1'b0, 1'b0, 2'd0)) begin
      $display("FAIL hit_in_countdown got %h want %h", snap(), exp_v(3'd1, 2'd3, 3'd5, 3'd5, 1'b0, 1'b0, 2'd0));
      n_err++;
    end
    nf_pulses(180);
    hit(1'b0, 1'b1);
    n_cmp++;
    if (snap() !== exp_v(3'd3, 2'd0, 3'd5, 3'd4, 1'b0, 1'b1, 2'd0)) begin
      $display("FAIL opp_hit got %h want %h", snap(), exp_v(3'd3, 2'd0, 3'd5, 3'd4, 1'b0, 1'b1, 2'd0));
      n_err++;
    end
    nf_pulses(29);
    ir_in = ABORT;
    ir_valid_in = 1'b1;
    nf_in = 1'b1;
    step();
    ir_valid_in = 1'b0;
    ir_in = '0;
    nf_in = 1'b0;
    n_cmp++;
    if ({game_state_out, display_start_out, freeze_out, countdown_out} !== {3'd0, 1'b1, 1'b0, 2'd0}) begin
      $display("FAIL abort_vs_tc got %h want %h", {game_state_out, display_start_out, freeze_out, countdown_out}, {3'd0, 1'b1, 1'b0, 2'd0});
      n_err++;
    end
  endtask

  task automatic test_reset_mid();
    send_ir(START_A);
    nf_pulses(10);
    rst_in = 1'b1;
    nf_in = 1'b1;
    step();
    nf_in = 1'b0;
    n_cmp++;
    if (snap() !== exp_v(3'd0, 2'd0, 3'd5, 3'd5, 1'b1, 1'b0, 2'd0)) begin
      $display("FAIL reset_mid got %h want %h", snap(), exp_v(3'd0, 2'd0, 3'd5, 3'd5, 1'b1, 1'b0, 2'd0));
      n_err++;
    end
    rst_in = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_start();
    test_countdown();
    test_hit_pause();
    test_draw();
    test_gameover_timeout();
    test_abort_pause();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
